rr_onehot_arbiter: RTL
======================

Name:
rr_onehot_arbiter

Overview:
- Round-robin arbiter that produces the registered one-hot select consumed by the downstream 2-D one-hot mux.
- Locks a grant across a multi-beat transfer until the granted requester's last beat is accepted.
- Advances a fairness pointer after each completed transfer.
- Sits between N requesting sources and the shared data path; its `gnt` drives the mux `sel` directly.

Parameters:
- CNT, 5, number of requesters (>=2)
- LOCK, 1, 1 = hold grant until last beat accepted; 0 = re-arbitrate after every accepted beat
- IDX_W, log2(CNT), width of encoded grant index (derived; not overridden)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req  input  CNT  per-requester request / beat valid
- last  input  CNT  per-requester last-beat flag, qualified by req
- out_rdy  input  1  downstream accepts current beat
- gnt  output  CNT  registered one-hot grant; all-zero when idle
- gnt_vld  output  1  registered; high iff gnt != 0
- gnt_idx  output  IDX_W  registered binary index of gnt; 0 when idle
- xfer  output  1  combinational: gnt_vld & |(req & gnt) & out_rdy
- err  output  1  sticky: granted requester dropped req before its last beat while LOCK=1

Behaviour:
- Reset (async, rst_n low):
  - gnt=0, gnt_vld=0, gnt_idx=0, err=0.
  - Pointer ptr=0, state=IDLE.
  - Release is synchronous to clk, via the normal async-assert flop style.
- States: IDLE, BUSY.
- Winner selection (combinational):
  - Search from ptr upward through CNT-1, wrapping to ptr-1, taking the first set bit of req.
  - Implemented as a double-width masked priority pick: win = first of (req & mask_ge_ptr), else first of req.
- IDLE:
  - If |req, register gnt = onehot(win) and gnt_idx = win, and go to BUSY.
  - Grant latency is 1 cycle from req assertion.
  - If req==0, remain IDLE with outputs 0.
- BUSY:
  - A beat transfers when xfer=1.
  - Completion = xfer & last[gnt_idx] (LOCK=1), or xfer alone (LOCK=0).
  - On completion, ptr <= gnt_idx+1, wrapping CNT-1 to 0.
  - Re-arbitration happens in the same cycle against the new pointer, excluding the just-served requester only if other requests are pending.
  - If another requester wins, register the new gnt next cycle and stay BUSY: zero-bubble back-to-back.
  - If none is pending, go to IDLE and clear gnt.
  - If the same requester is the only one pending, it is re-granted; it is never starved and never bubbles.
- No completion: gnt holds unchanged regardless of other req changes.
- Stalls: out_rdy low holds every register; ptr does not move.
- Dropped request:
  - With LOCK=1, if the granted req falls while BUSY without completion, set err=1 (sticky until reset) and keep holding the grant.
  - With LOCK=0, the grant is released to IDLE the next cycle and err is unaffected.
- Output invariant: gnt is always zero or one-hot, so a one-hot checker on the mux never fires.
- Simultaneous events: a request arriving in the completion cycle is eligible for that cycle's re-arbitration.
- Reset mid-transfer: all outputs drop immediately (async) and ptr returns to 0.

Decomposition:
- Shared package:
  - log2 helper (common function include)
  - state encoding constants ST_IDLE / ST_BUSY
  - IDX_W derivation
- One natural sub-module: rr_pick, a combinational masked round-robin priority picker (req, ptr -> onehot win, win_idx).
- The registered FSM/pointer stays in the top.

Test Plan:
- CNT=4, req=4'b1010 from reset, out_rdy=1, last always 1 -> gnt 0010, then 1000, then 0010; one beat each, gnt_idx 1,3,1; no idle bubble.
- LOCK=1, req=4'b0011, last[0] at beat 3, out_rdy=1 -> gnt=0001 for 3 xfers, then 0010 on the following cycle; ptr advances to 1.
- Grant 0100 active with out_rdy=0 for 5 cycles while req[0] toggles -> gnt stays 0100, ptr unchanged, xfer=0.
- Single requester req=4'b1000, last=1 continuous -> gnt=1000 held every cycle, xfer every cycle, ptr wraps to 0 each completion.
- LOCK=1, granted req drops before last -> err=1 next cycle and stays high; gnt unchanged; err clears only on rst_n.
- rst_n low mid-transfer with gnt=0010 -> gnt=0, gnt_vld=0 asynchronously; after release, req=4'b1111 -> gnt=0001.

Source files
------------

// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared definitions for the round-robin one-hot arbiter.
//   rr_log2 : ceiling log2, used to derive the grant index width
//   state_t : arbiter FSM states
package rr_onehot_arbiter_pkg;

  function automatic int rr_log2(input int unsigned n);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) r = int'(i) + 1;
    end
    return r;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_onehot_arbiter_pick.sv
// Combinational round-robin priority picker.
//   req     : request vector
//   ptr     : index with highest priority this round
//   win     : one-hot winner (zero when req == 0)
//   win_idx : binary index of win (zero when req == 0)
//   any     : |req
module rr_pick
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int CNT = 5,
  localparam int IDX_W = rr_log2(CNT)
) (
  input  logic [CNT-1:0]   req,
  input  logic [IDX_W-1:0] ptr,
  output logic [CNT-1:0]   win,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [CNT-1:0]   mask;
  logic [2*CNT-1:0] dbl;

  // Lower half holds requests at or above ptr, upper half all requests;
  // the lowest set bit of the concatenation is the wrapped round-robin winner.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < CNT; i++) begin
      mask[i] = (i >= 32'(ptr));
    end
    dbl     = {req, req & mask};
    win_idx = '0;
    for (int unsigned i = 2 * CNT; i > 0; i--) begin
      if (dbl[i-1]) win_idx = IDX_W'((i - 1) % CNT);
    end
    any = |req;
    win = any ? (CNT'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter producing a registered one-hot select for a one-hot mux.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester request / beat valid
//   last       : per-requester last-beat flag (qualified by req)
//   out_rdy    : downstream accepts the current beat
//   gnt        : registered one-hot grant, zero when idle
//   gnt_vld    : high iff gnt != 0
//   gnt_idx    : binary index of gnt, zero when idle
//   xfer       : a beat of the granted requester is accepted this cycle
//   err        : sticky, granted requester dropped req before its last beat (LOCK=1)
module rr_onehot_arbiter
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int CNT  = 5,
  parameter bit LOCK = 1'b1,
  localparam int IDX_W = rr_log2(CNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT-1:0]   req,
  input  logic [CNT-1:0]   last,
  input  logic             out_rdy,
  output logic [CNT-1:0]   gnt,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             xfer,
  output logic             err
);

  state_t           state, state_n;
  logic [CNT-1:0]   gnt_n;
  logic [IDX_W-1:0] idx_n;
  logic [IDX_W-1:0] ptr, ptr_n, ptr_adv, pick_ptr;
  logic             err_n;
  logic [CNT-1:0]   win;
  logic [IDX_W-1:0] win_idx;
  logic             any;
  logic             held, done, drop;

  assign gnt_vld  = (state == ST_BUSY);
  assign held     = |(req & gnt);
  assign xfer     = gnt_vld & held & out_rdy;
  assign done     = xfer & (LOCK ? |(last & gnt) : 1'b1);
  assign drop     = gnt_vld & ~held;
  assign ptr_adv  = (gnt_idx == IDX_W'(CNT - 1)) ? '0 : gnt_idx + IDX_W'(1);
  // Re-arbitrate against the advanced pointer in the completion cycle so the
  // served requester ranks last and only wins when nothing else is pending.
  assign pick_ptr = done ? ptr_adv : ptr;

  rr_pick #(.CNT(CNT)) u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    idx_n   = gnt_idx;
    ptr_n   = ptr;
    err_n   = err;
    unique case (state)
      ST_IDLE: begin
        if (any) begin
          gnt_n   = win;
          idx_n   = win_idx;
          state_n = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A dropped request is acted on even while out_rdy is low.
        if (drop) begin
          if (LOCK) begin
            err_n = 1'b1;
          end else begin
            state_n = ST_IDLE;
            gnt_n   = '0;
            idx_n   = '0;
          end
        end else if (done) begin
          ptr_n = ptr_adv;
          if (any) begin
            gnt_n = win;
            idx_n = win_idx;
          end else begin
            state_n = ST_IDLE;
            gnt_n   = '0;
            idx_n   = '0;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      ptr     <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      gnt_idx <= idx_n;
      ptr     <= ptr_n;
      err     <= err_n;
    end
  end

endmodule
